imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL provide parameter ADDR_W, default 8, giving the instruction-memory word-address width (256 words).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  level-sampled load request.
REQ-005 SHALL have port rx_valid  input  1  a byte is offered on rx_byte.
REQ-006 SHALL have port rx_byte  input  8  the offered serial-stream byte.
REQ-007 SHALL have port rx_ready  output  1  the loader accepts rx_byte this cycle.
REQ-008 SHALL have port imem_we  output  1  one-cycle instruction-memory write strobe.
REQ-009 SHALL have port imem_addr  output  ADDR_W  instruction-memory word address.
REQ-010 SHALL have port imem_wdata  output  32  instruction word to write.
REQ-011 SHALL have port core_hold  output  1  holds the processor datapath in reset while high.
REQ-012 SHALL have port done  output  1  load completed with a good checksum.
REQ-013 SHALL have port error  output  1  load completed with a bad checksum.

Function
REQ-014 SHALL transfer a byte only on a rising edge where rx_valid and rx_ready are both high.
REQ-015 SHALL implement states IDLE, LEN, DATA, WRITE, CHECK, DONE, ERR.
REQ-016 SHALL move IDLE->LEN when start is high; start is ignored in LEN, DATA, WRITE, CHECK; start in DONE or ERR SHALL move to LEN, clear done/error, and zero the address and checksum.
REQ-017 SHALL, in LEN, take the first transferred byte as word count N (N=0 means 2^ADDR_W words), then move to DATA.
REQ-018 SHALL, in DATA, assemble bytes little-endian (first byte -> bits 7:0, fourth -> bits 31:24) with a 2-bit byte counter.
REQ-019 SHALL XOR every data byte into an 8-bit running checksum; the length byte SHALL NOT be included.
REQ-020 SHALL, on the 4th byte transfer, move to WRITE; in WRITE, imem_we=1 for exactly one cycle with imem_wdata = assembled word and imem_addr = current word address.
REQ-021 SHALL increment imem_addr after each write (modulo 2^ADDR_W) and decrement the remaining-word count.
REQ-022 SHALL return WRITE->DATA while words remain, and WRITE->CHECK after the Nth word.
REQ-023 SHALL hold rx_ready high only in LEN, DATA, CHECK; low in IDLE, WRITE, DONE, ERR (one bubble per word).
REQ-024 SHALL, in CHECK, compare the transferred byte to the running checksum: equal -> DONE, else -> ERR.
REQ-025 SHALL drive done=1 only in DONE and error=1 only in ERR.
REQ-026 SHALL drive core_hold=1 in every state except DONE; core_hold SHALL fall on the edge entering DONE.
REQ-027 SHALL keep imem_we=0 outside WRITE; imem_wdata and imem_addr hold their last values otherwise.
REQ-028 SHALL latch rx_byte so imem_wdata never depends combinationally on rx_byte.

Reset
REQ-029 SHALL, while reset=0, immediately force state IDLE, rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, checksum=0, byte/word counters=0, done=0, error=0, core_hold=1.
REQ-030 SHALL abandon a load in progress on reset assertion; words already written stay in memory; a new start is required.
REQ-031 SHALL leave IDLE no earlier than the first rising edge after reset deasserts.

Verification
REQ-032 Single word: start, bytes 01,13,05,A0,00,B6 -> one imem_we at addr 0 with wdata 0x00A00513, then done=1, core_hold=0.
REQ-033 Bad checksum: bytes 01,13,05,A0,00,00 -> one write at addr 0, then error=1, done=0, core_hold stays 1.
REQ-034 Backpressure: 3 words with rx_valid toggling every cycle -> writes at addr 0,1,2 exactly once each, one rx_ready-low bubble after every 4th data byte.
REQ-035 Full memory: N=00 with 1024 data bytes -> 256 writes, addr wraps 255->0 without an extra write, then CHECK.
REQ-036 Reset mid-load: reset=0 after 6 data bytes -> outputs at reset values immediately; next start with N=1 writes addr 0.
REQ-037 Restart: start held high in DONE -> done clears, core_hold=1 next cycle, LEN accepts a new length byte.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory loader.
// Consumes a byte stream  [N] [4*N data bytes, little-endian words] [XOR checksum],
// writes each assembled word to instruction memory, and holds the core in reset
// until a load finishes with a matching checksum.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              error
);

    // Remaining-word counter must hold both 2^ADDR_W (N=0) and any 8-bit N.
    localparam int CNT_W = ((ADDR_W >= 8) ? ADDR_W : 8) + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_t;

    state_t             state;
    logic [1:0]         byte_cnt;
    logic [23:0]        word_buf;   // bytes 0..2 of the word being assembled
    logic [7:0]         csum;
    logic [CNT_W-1:0]   words_left;
    logic               xfer;

    assign xfer = rx_valid && rx_ready;

    // Loader FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rx_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            csum       <= '0;
            byte_cnt   <= '0;
            word_buf   <= '0;
            words_left <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            core_hold  <= 1'b1;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state     <= LEN;
                        rx_ready  <= 1'b1;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        core_hold <= 1'b1;
                        imem_addr <= '0;
                        csum      <= '0;
                        byte_cnt  <= '0;
                    end
                end
                LEN: begin
                    if (xfer) begin
                        // A zero length byte means a full-memory image.
                        words_left <= (rx_byte == 8'd0) ? (CNT_W'(1) << ADDR_W)
                                                        : CNT_W'(rx_byte);
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        csum     <= csum ^ rx_byte;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            imem_wdata <= {rx_byte, word_buf};
                            imem_we    <= 1'b1;
                            rx_ready   <= 1'b0;
                            state      <= WRITE;
                        end else begin
                            word_buf[8*byte_cnt +: 8] <= rx_byte;
                        end
                    end
                end
                WRITE: begin
                    // Single write cycle; this is also the per-word rx bubble.
                    imem_we    <= 1'b0;
                    rx_ready   <= 1'b1;
                    imem_addr  <= imem_addr + 1'b1;
                    words_left <= words_left - 1'b1;
                    state      <= (words_left == CNT_W'(1)) ? CHECK : DATA;
                end
                CHECK: begin
                    if (xfer) begin
                        rx_ready <= 1'b0;
                        if (rx_byte == csum) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            core_hold <= 1'b0;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    rx_ready <= 1'b0;
                    imem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes are queued as each word is
// sent and checked against imem_we strobes by a monitor.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_hold;
    logic        done;
    logic        error;

    int          checks = 0;
    int          errors = 0;
    logic [39:0] exp_q[$];
    logic [39:0] mon_exp;
    logic [7:0]  csum;

    imem_loader #(.ADDR_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest queued word.
    always @(negedge clk) begin
        if (reset && imem_we === 1'b1) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_write got addr %h data %h expected none", imem_addr, imem_wdata);
            end
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                chk("write", {imem_addr, imem_wdata}, mon_exp);
                chk("write_bubble", {39'd0, rx_ready}, 40'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Caller sits on a negedge; returns on the negedge after the transfer edge.
    task automatic send(input logic [7:0] b, input bit gap);
        int n;
        if (gap) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_byte  = b;
        n = 0;
        while (rx_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $error("FAIL rx_ready_timeout got 0 expected 1");
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] addr, input logic [31:0] w, input bit gap);
        exp_q.push_back({addr, w});
        for (int i = 0; i < 4; i++) begin
            csum ^= w[8*i +: 8];
            send(w[8*i +: 8], gap);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_outputs", {33'd0, rx_ready, imem_we, done, error, core_hold, 2'b00},
                           {33'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00});
        chk("rst_addr_data", {imem_addr, imem_wdata}, 40'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_no_ready", {39'd0, rx_ready}, 40'd0);

        // Single word, good checksum
        do_start();
        chk("len_ready", {38'd0, rx_ready, core_hold}, {38'd0, 2'b11});
        send(8'h01, 1'b0);
        csum = 8'h00;
        send_word(8'h00, 32'h00A00513, 1'b0);
        send(8'hB6, 1'b0);
        chk("single_done", {37'd0, done, error, core_hold}, {37'd0, 3'b100});
        chk("single_q", 40'(exp_q.size()), 40'd0);

        // Restart from DONE with start held, then bad checksum
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        chk("restart", {37'd0, done, core_hold, rx_ready}, {37'd0, 3'b011});
        send(8'h01, 1'b0);
        start = 1'b0;
        csum = 8'h00;
        send_word(8'h00, 32'h00A00513, 1'b0);
        send(8'h00, 1'b0);
        chk("bad_csum", {37'd0, done, error, core_hold}, {37'd0, 3'b011});

        // Three words with rx_valid toggling
        do_start();
        chk("err_cleared", {39'd0, error}, 40'd0);
        send(8'h03, 1'b1);
        csum = 8'h00;
        for (int i = 0; i < 3; i++) send_word(8'(i), $urandom, 1'b1);
        send(csum, 1'b1);
        chk("bp_done", {37'd0, done, error, core_hold}, {37'd0, 3'b100});
        chk("bp_q", 40'(exp_q.size()), 40'd0);

        // Full memory, N=0
        do_start();
        send(8'h00, 1'b0);
        csum = 8'h00;
        for (int i = 0; i < 256; i++) send_word(8'(i), $urandom, 1'b0);
        @(negedge clk);
        chk("full_wrap", {30'd0, imem_addr, rx_ready, done}, {30'd0, 8'h00, 1'b1, 1'b0});
        chk("full_q", 40'(exp_q.size()), 40'd0);
        send(csum, 1'b0);
        chk("full_done", {38'd0, done, error}, {38'd0, 2'b10});

        // Reset mid-load after 6 data bytes
        do_start();
        send(8'h02, 1'b0);
        csum = 8'h00;
        send_word(8'h00, 32'hDEADBEEF, 1'b0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        reset = 1'b0;
        #1;
        chk("mid_rst_outputs", {35'd0, rx_ready, imem_we, done, error, core_hold},
                               {35'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        chk("mid_rst_addr_data", {imem_addr, imem_wdata}, 40'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_idle", {38'd0, rx_ready, done}, 40'd0);
        chk("mid_rst_q", 40'(exp_q.size()), 40'd0);
        do_start();
        send(8'h01, 1'b0);
        csum = 8'h00;
        send_word(8'h00, 32'h12345678, 1'b0);
        send(csum, 1'b0);
        chk("reload_done", {37'd0, done, error, core_hold}, {37'd0, 3'b100});
        chk("reload_q", 40'(exp_q.size()), 40'd0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
